// File: rtl/brew_scheduler.sv
// brew_scheduler: round-robin arbiter and phase sequencer that shares one grinder/brewer/milk
// unit between NUM_REQ payment front-ends. Every output is registered and reflects the
// state the FSM was in one cycle earlier, so the supply abort is judged against the
// actuator that is actually on.
// Optional feature: define BREW_STATS_EN to add the cups_served / fails_seen counters.
module brew_scheduler #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned GRIND_CYCLES = 4,
    parameter int unsigned BREW_CYCLES  = 8,
    parameter int unsigned MILK_CYCLES  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_milk,
    input  logic               coffee_available,
    input  logic               milk_available,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] fail,
    output logic               busy,
    output logic               grinder_on,
    output logic               heater_on,
    output logic               milk_valve,
    output logic               err_supply
`ifdef BREW_STATS_EN
    ,
    output logic [15:0]        cups_served,
    output logic [7:0]         fails_seen
`endif
);

    localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned MaxGB  = (GRIND_CYCLES > BREW_CYCLES) ? GRIND_CYCLES : BREW_CYCLES;
    localparam int unsigned MaxCyc = (MaxGB > MILK_CYCLES) ? MaxGB : MILK_CYCLES;
    localparam int unsigned TimerW = $clog2(MaxCyc + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StGrind,
        StBrew,
        StMilk,
        StDone,
        StFail
    } state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      id_q, id_d;
    logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                milk_q, milk_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  fail_q, fail_d;
    logic                busy_q, busy_d;
    logic                grinder_q, grinder_d;
    logic                heater_q, heater_d;
    logic                milk_valve_q, milk_valve_d;
    logic                err_q, err_d;

    logic                arb_found;
    logic [IdW-1:0]      arb_id;
    logic [NUM_REQ-1:0]  id_onehot;
    logic                abort;

    assign id_onehot = NUM_REQ'(1) << id_q;

    // Supply lost while its actuator is actually running.
    assign abort = ((grinder_q | heater_q) & ~coffee_available) | (milk_valve_q & ~milk_available);

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        logic [IdW-1:0] cand;
        arb_found = 1'b0;
        arb_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IdW'(idx);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_id    = cand;
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        rr_ptr_d     = rr_ptr_q;
        milk_d       = milk_q;
        timer_d      = timer_q;
        grant_d      = '0;
        done_d       = '0;
        fail_d       = '0;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    id_d     = arb_id;
                    milk_d   = req_milk[arb_id];
                    rr_ptr_d = (arb_id == IdW'(NUM_REQ - 1)) ? '0 : arb_id + IdW'(1);
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (!coffee_available || (milk_q && !milk_available)) begin
                    state_d = StFail;
                end else begin
                    state_d = StGrind;
                    timer_d = TimerW'(GRIND_CYCLES - 1);
                end
            end
            StGrind: begin
                if (timer_q == '0) begin
                    state_d = StBrew;
                    timer_d = TimerW'(BREW_CYCLES - 1);
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StBrew: begin
                if (timer_q == '0) begin
                    if (milk_q) begin
                        state_d = StMilk;
                        timer_d = TimerW'(MILK_CYCLES - 1);
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StMilk: begin
                if (timer_q == '0) begin
                    state_d = StDone;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StDone:  state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort can only be raised while an actuator is on, i.e. GRIND..DONE.
        if (abort) begin
            state_d = StFail;
        end

        if (state_q == StCheck && state_d == StGrind) begin
            grant_d = id_onehot;
        end
        if (state_q == StDone && !abort) begin
            done_d = id_onehot;
        end
        // Fail pulses on entry to FAIL so it lines up with the actuator drop.
        if (state_d == StFail && state_q != StFail) begin
            fail_d = id_onehot;
        end

        busy_d       = (state_q != StIdle);
        grinder_d    = (state_q == StGrind) && !abort;
        heater_d     = (state_q == StBrew) && !abort;
        milk_valve_d = (state_q == StMilk) && !abort;

        if (|fail_d) begin
            err_d = 1'b1;
        end else if (|grant_d) begin
            err_d = 1'b0;
        end
    end

    // State and output registers; async reset forces actuators off immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            id_q         <= '0;
            rr_ptr_q     <= '0;
            milk_q       <= 1'b0;
            timer_q      <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            fail_q       <= '0;
            busy_q       <= 1'b0;
            grinder_q    <= 1'b0;
            heater_q     <= 1'b0;
            milk_valve_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            rr_ptr_q     <= rr_ptr_d;
            milk_q       <= milk_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            busy_q       <= busy_d;
            grinder_q    <= grinder_d;
            heater_q     <= heater_d;
            milk_valve_q <= milk_valve_d;
            err_q        <= err_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign busy       = busy_q;
    assign grinder_on = grinder_q;
    assign heater_on  = heater_q;
    assign milk_valve = milk_valve_q;
    assign err_supply = err_q;

`ifdef BREW_STATS_EN
    logic [15:0] cups_q, cups_d;
    logic [7:0]  fails_q, fails_d;

    // Cups wrap; fail count saturates.
    always_comb begin
        cups_d  = cups_q;
        fails_d = fails_q;
        if (|done_d) begin
            cups_d = cups_q + 16'd1;
        end
        if (|fail_d && fails_q != 8'hFF) begin
            fails_d = fails_q + 8'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cups_q  <= '0;
            fails_q <= '0;
        end else begin
            cups_q  <= cups_d;
            fails_q <= fails_d;
        end
    end

    assign cups_served = cups_q;
    assign fails_seen  = fails_q;
`endif

endmodule
